// File: rtl/maquina_pkg.sv
// Shared definitions for the beverage machine controller and the display
// decoders: FSM state encoding, status codes driven on the sensor bus, the
// valid beverage code range and small helpers.
`timescale 1ns/1ps
package maquina_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_FILL  = 3'd2,
      ST_MIX   = 3'd3,
      ST_MSG   = 3'd4,
      ST_FAULT = 3'd5
   } estado_t;

   typedef logic [2:0] status_t;

   localparam status_t SENS_OK         = 3'b000;
   localparam status_t SENS_NO_CUP     = 3'b001;
   localparam status_t SENS_LOW_WATER  = 3'b010;
   localparam status_t SENS_LOW_ING    = 3'b011;
   localparam status_t SENS_DISPENSING = 3'b100;
   localparam status_t SENS_DONE       = 3'b101;
   localparam status_t SENS_CANCEL     = 3'b110;

   localparam logic [2:0] BEBIDA_NONE = 3'd0;
   localparam logic [2:0] BEBIDA_MIN  = 3'd1;
   localparam logic [2:0] BEBIDA_MAX  = 3'd5;

   function automatic logic bebida_valida(input logic [2:0] code);
      return (code >= BEBIDA_MIN) && (code <= BEBIDA_MAX);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/botao_sync.sv
// Pushbutton front end: 2-flop synchronizer, optional debounce and rising
// edge detector producing a single-cycle pulse.
// Optional feature macro: DEBOUNCE_EN (debounce filter with a per-button
// down-counter; without it the edge detector works on the synchronizer).
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   botao  - raw asynchronous button level, active-high
//   pulso  - one-cycle pulse on an accepted rising edge
`timescale 1ns/1ps
module botao_sync
`ifdef DEBOUNCE_EN
   #(parameter int DEBOUNCE_CYCLES = 16)
`endif
   (
   input  logic clk,
   input  logic rst_n,
   input  logic botao,
   output logic pulso
   );

   logic sync_a;
   logic sync_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= botao;
         sync_b <= sync_a;
      end
   end

`ifdef DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

   logic          estavel;
   logic [CW-1:0] cnt;

   // Accepted level starts high so a button held through reset never looks
   // like a fresh press once the synchronizer fills.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estavel <= 1'b1;
         cnt     <= CNT_LOAD;
      end else if (sync_b == estavel) begin
         cnt <= CNT_LOAD;
      end else if (cnt == '0) begin
         estavel <= sync_b;
         cnt     <= CNT_LOAD;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   assign pulso = sync_b & ~estavel & (cnt == '0);
`else
   logic [1:0] primed;
   logic       prev;

   // Until the synchronizer holds real samples, prev is pinned high so a
   // level present at reset release cannot produce a pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         primed <= 2'b00;
         prev   <= 1'b1;
      end else begin
         primed <= {primed[0], 1'b1};
         prev   <= primed[1] ? sync_b : 1'b1;
      end
   end

   assign pulso = sync_b & ~prev & primed[1];
`endif

endmodule

// File: rtl/controlador_maquina.sv
// Beverage machine sequencer: latches a beverage selection, checks the
// sensors, runs the water and mix valves for fixed times, then holds a
// done/cancel code for the display before returning to idle.
// Optional feature macro: DEBOUNCE_EN (button debounce in botao_sync).
// Ports:
//   clk, rst_n                        - clock, async active-low reset
//   sel[2:0]                          - beverage switches (1..5 valid)
//   confirm, cancel                   - async pushbuttons, active-high
//   cup_present, water_ok, ingredient_ok - level sensors, 1 = ok
//   bebida[2:0]                       - latched beverage code
//   sensor[2:0]                       - status code
//   valve_water, valve_mix            - actuator enables
//   busy                              - high outside IDLE
//
// state    | meaning
// ---------+----------------------------------------------------
// IDLE     | waiting for confirm with a valid selection
// CHECK    | one-cycle sensor check (cup > water > ingredient)
// FILL     | water valve open for FILL_CYCLES
// MIX      | mix valve open for MIX_CYCLES
// MSG      | done/cancel code held for MSG_CYCLES
// FAULT    | fault code held; confirm retries, cancel aborts
`timescale 1ns/1ps
module controlador_maquina
   import maquina_pkg::*;
   #(
   parameter int FILL_CYCLES     = 50,
   parameter int MIX_CYCLES      = 30,
   parameter int MSG_CYCLES      = 100,
   parameter int DEBOUNCE_CYCLES = 16
   )(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] sel,
   input  logic       confirm,
   input  logic       cancel,
   input  logic       cup_present,
   input  logic       water_ok,
   input  logic       ingredient_ok,
   output logic [2:0] bebida,
   output logic [2:0] sensor,
   output logic       valve_water,
   output logic       valve_mix,
   output logic       busy
   );

   localparam int TMAX = max3(FILL_CYCLES, MIX_CYCLES, MSG_CYCLES);
   localparam int TW   = $clog2(TMAX) + 1;
   localparam logic [TW-1:0] T_FILL = TW'(FILL_CYCLES - 1);
   localparam logic [TW-1:0] T_MIX  = TW'(MIX_CYCLES - 1);
   localparam logic [TW-1:0] T_MSG  = TW'(MSG_CYCLES - 1);

   logic          confirm_p;
   logic          cancel_p;
   estado_t       state;
   estado_t       state_next;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_next;
   logic          tc;
   status_t       code_next;
   logic [2:0]    bebida_next;
   status_t       sensor_d;
   logic          valve_water_d;
   logic          valve_mix_d;
   logic          busy_d;

   botao_sync
`ifdef DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_sync_confirm (
      .clk   (clk),
      .rst_n (rst_n),
      .botao (confirm),
      .pulso (confirm_p)
   );

   botao_sync
`ifdef DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_sync_cancel (
      .clk   (clk),
      .rst_n (rst_n),
      .botao (cancel),
      .pulso (cancel_p)
   );

   assign tc = (timer == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         timer <= '0;
      end else begin
         state <= state_next;
         timer <= timer_next;
      end
   end

   // Cancel is evaluated before any fault so it wins same-cycle conflicts.
   always_comb begin
      state_next  = state;
      code_next   = sensor;
      bebida_next = bebida;
      case (state)
         ST_IDLE: begin
            if (confirm_p && bebida_valida(sel)) begin
               state_next  = ST_CHECK;
               bebida_next = sel;
            end
         end
         ST_CHECK: begin
            if (cancel_p) begin
               state_next = ST_MSG;
               code_next  = SENS_CANCEL;
            end else if (!cup_present) begin
               state_next = ST_FAULT;
               code_next  = SENS_NO_CUP;
            end else if (!water_ok) begin
               state_next = ST_FAULT;
               code_next  = SENS_LOW_WATER;
            end else if (!ingredient_ok) begin
               state_next = ST_FAULT;
               code_next  = SENS_LOW_ING;
            end else begin
               state_next = ST_FILL;
            end
         end
         ST_FILL, ST_MIX: begin
            if (cancel_p) begin
               state_next = ST_MSG;
               code_next  = SENS_CANCEL;
            end else if (!cup_present) begin
               state_next = ST_FAULT;
               code_next  = SENS_NO_CUP;
            end else if (tc) begin
               if (state == ST_FILL) begin
                  state_next = ST_MIX;
               end else begin
                  state_next = ST_MSG;
                  code_next  = SENS_DONE;
               end
            end
         end
         ST_MSG: begin
            if (tc) begin
               state_next  = ST_IDLE;
               bebida_next = BEBIDA_NONE;
            end
         end
         ST_FAULT: begin
            if (cancel_p) begin
               state_next  = ST_IDLE;
               bebida_next = BEBIDA_NONE;
            end else if (confirm_p) begin
               state_next = ST_CHECK;
            end
         end
         default: begin
            state_next  = ST_IDLE;
            bebida_next = BEBIDA_NONE;
         end
      endcase

      // Down-counter reloaded on every state change; terminal count is zero.
      if (state_next != state) begin
         case (state_next)
            ST_FILL: timer_next = T_FILL;
            ST_MIX:  timer_next = T_MIX;
            ST_MSG:  timer_next = T_MSG;
            default: timer_next = '0;
         endcase
      end else if (!tc) begin
         timer_next = timer - 1'b1;
      end else begin
         timer_next = timer;
      end
   end

   // Outputs are decoded from the next state and registered alongside it,
   // so they change on the same edge as the state register.
   always_comb begin
      valve_water_d = (state_next == ST_FILL);
      valve_mix_d   = (state_next == ST_MIX);
      busy_d        = (state_next != ST_IDLE);
      case (state_next)
         ST_FILL, ST_MIX: sensor_d = SENS_DISPENSING;
         ST_MSG, ST_FAULT: sensor_d = code_next;
         default:         sensor_d = SENS_OK;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bebida      <= BEBIDA_NONE;
         sensor      <= SENS_OK;
         valve_water <= 1'b0;
         valve_mix   <= 1'b0;
         busy        <= 1'b0;
      end else begin
         bebida      <= bebida_next;
         sensor      <= sensor_d;
         valve_water <= valve_water_d;
         valve_mix   <= valve_mix_d;
         busy        <= busy_d;
      end
   end

endmodule

// File: tb/tb_controlador_maquina.sv
`timescale 1ns/1ps
module tb_controlador_maquina;

   localparam int DEB = 16;
`ifdef DEBOUNCE_EN
   localparam int LAT   = 2 + DEB - 1;
   localparam int PRESS = 24;
`else
   localparam int LAT   = 2;
   localparam int PRESS = 4;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] sel = 3'd0;
   logic       confirm = 1'b0;
   logic       cancel = 1'b0;
   logic       cup_present = 1'b1;
   logic       water_ok = 1'b1;
   logic       ingredient_ok = 1'b1;
   logic [2:0] bebida;
   logic [2:0] sensor;
   logic       valve_water;
   logic       valve_mix;
   logic       busy;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [8:0] tup;
      int         len;
   } seg_t;

   seg_t sb[$];

   controlador_maquina #(
      .FILL_CYCLES(50), .MIX_CYCLES(30), .MSG_CYCLES(100), .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sel(sel), .confirm(confirm), .cancel(cancel),
      .cup_present(cup_present), .water_ok(water_ok), .ingredient_ok(ingredient_ok),
      .bebida(bebida), .sensor(sensor), .valve_water(valve_water),
      .valve_mix(valve_mix), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [8:0] tup();
      return {bebida, sensor, valve_water, valve_mix, busy};
   endfunction

   function automatic logic [8:0] mk(input logic [2:0] b, input logic [2:0] s,
                                     input logic w, input logic m, input logic y);
      return {b, s, w, m, y};
   endfunction

   task automatic push(input logic [8:0] t, input int len);
      seg_t e;
      e.tup = t;
      e.len = len;
      sb.push_back(e);
   endtask

   task automatic press_confirm(input int hold);
      confirm = 1'b1;
      repeat (hold) @(negedge clk);
      confirm = 1'b0;
      repeat (PRESS) @(negedge clk);
   endtask

   task automatic press_cancel(input int hold);
      cancel = 1'b1;
      repeat (hold) @(negedge clk);
      cancel = 1'b0;
      repeat (PRESS) @(negedge clk);
   endtask

   // Waits for the outputs to leave their present value, then measures
   // nseg constant-output segments and compares each against the scoreboard.
   task automatic observe(input int nseg, input string name);
      logic [8:0] cur;
      int n;
      seg_t e;
      @(negedge clk);
      cur = tup();
      n = 0;
      while (tup() == cur && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         checks++;
         failures++;
         $display("FAIL %s_start got=no_change exp=change", name);
         sb.delete();
         return;
      end
      for (int s = 0; s < nseg; s++) begin
         cur = tup();
         n = 0;
         while (tup() == cur && n < 1000) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s_seg%0d got=%h exp=queue_entry", name, s, cur);
         end else begin
            e = sb.pop_front();
            if (cur !== e.tup) begin
               failures++;
               $display("FAIL %s_seg%0d_outputs got=%h exp=%h", name, s, cur, e.tup);
            end
            checks++;
            if (n !== e.len) begin
               failures++;
               $display("FAIL %s_seg%0d_length got=%0d exp=%0d", name, s, n, e.len);
            end
         end
      end
   endtask

   task automatic wait_valve(input bit mix);
      int n = 0;
      @(negedge clk);
      while (!(mix ? valve_mix : valve_water) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         checks++;
         failures++;
         $display("FAIL wait_valve%0d got=low exp=high", mix);
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (tup() !== 9'h000) begin
         failures++;
         $display("FAIL %s_idle got=%h exp=%h", name, tup(), 9'h000);
      end
   endtask

   task automatic check_idle(input string name);
      checks++;
      if (tup() !== 9'h000) begin
         failures++;
         $display("FAIL %s_idle got=%h exp=%h", name, tup(), 9'h000);
      end
   endtask

   task automatic push_flow(input logic [2:0] b);
      push(mk(b, 3'b000, 0, 0, 1), 1);
      push(mk(b, 3'b100, 1, 0, 1), 50);
      push(mk(b, 3'b100, 0, 1, 1), 30);
      push(mk(b, 3'b101, 0, 0, 1), 100);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset_asserted");
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check_idle("reset_released");
   endtask

   task automatic test_normal(input logic [2:0] b);
      sel = b;
      push_flow(b);
      fork
         press_confirm(PRESS);
         observe(4, "normal");
      join
      check_idle("normal_end");
   endtask

   task automatic test_back_to_back();
      test_normal(3'd1);
      test_normal(3'd5);
   endtask

   task automatic test_invalid();
      logic [2:0] codes [3];
      logic seen;
      codes[0] = 3'd0;
      codes[1] = 3'd6;
      codes[2] = 3'd7;
      for (int i = 0; i < 3; i++) begin
         sel = codes[i];
         seen = 1'b0;
         fork
            press_confirm(PRESS);
            repeat (2 * PRESS + 10) begin
               @(negedge clk);
               seen = seen | busy;
            end
         join
         checks++;
         if (seen !== 1'b0 || tup() !== 9'h000) begin
            failures++;
            $display("FAIL invalid_sel%0d got=busy%0d/%h exp=busy0/%h", codes[i], seen, tup(), 9'h000);
         end
      end
   endtask

   task automatic test_faults();
      logic [2:0] b;
      logic [2:0] code;
      logic bad;
      for (int i = 0; i < 3; i++) begin
         cup_present   = (i > 0);
         water_ok      = (i > 1);
         ingredient_ok = 1'b0;
         code = (i == 0) ? 3'b001 : ((i == 1) ? 3'b010 : 3'b011);
         b    = (i == 0) ? 3'd2 : 3'(i + 3);
         sel  = b;
         push(mk(b, 3'b000, 0, 0, 1), 1);
         fork
            press_confirm(PRESS);
            observe(1, "fault_check");
         join
         checks++;
         if (tup() !== mk(b, code, 0, 0, 1)) begin
            failures++;
            $display("FAIL fault_code%0d got=%h exp=%h", i, tup(), mk(b, code, 0, 0, 1));
         end
         bad = 1'b0;
         repeat (20) begin
            @(negedge clk);
            bad = bad | valve_water | valve_mix | (tup() !== mk(b, code, 0, 0, 1));
         end
         checks++;
         if (bad !== 1'b0) begin
            failures++;
            $display("FAIL fault_hold%0d got=changed exp=held", i);
         end
         if (i == 0) begin
            cup_present   = 1'b1;
            ingredient_ok = 1'b1;
            water_ok      = 1'b1;
            push_flow(b);
            fork
               press_confirm(PRESS);
               observe(4, "fault_retry");
            join
            check_idle("fault_retry_end");
         end else begin
            fork
               press_cancel(PRESS);
               wait_idle("fault_cancel");
            join
         end
      end
      cup_present   = 1'b1;
      water_ok      = 1'b1;
      ingredient_ok = 1'b1;
   endtask

   task automatic test_cancel_fill();
      sel = 3'd1;
      push(mk(3'd1, 3'b000, 0, 0, 1), 1);
      push(mk(3'd1, 3'b100, 1, 0, 1), 10 + LAT);
      push(mk(3'd1, 3'b110, 0, 0, 1), 100);
      fork
         press_confirm(PRESS);
         observe(3, "cancel_fill");
         begin
            wait_valve(1'b0);
            repeat (9) @(negedge clk);
            press_cancel(PRESS);
         end
      join
      check_idle("cancel_fill_end");
   endtask

   task automatic test_cup_loss_fill();
      sel = 3'd5;
      push(mk(3'd5, 3'b000, 0, 0, 1), 1);
      push(mk(3'd5, 3'b100, 1, 0, 1), 20);
      fork
         press_confirm(PRESS);
         observe(2, "cup_loss");
         begin
            wait_valve(1'b0);
            repeat (19) @(negedge clk);
            cup_present = 1'b0;
         end
      join
      checks++;
      if (tup() !== mk(3'd5, 3'b001, 0, 0, 1)) begin
         failures++;
         $display("FAIL cup_loss_fault got=%h exp=%h", tup(), mk(3'd5, 3'b001, 0, 0, 1));
      end
      fork
         press_cancel(PRESS);
         wait_idle("cup_loss_cancel");
      join
      cup_present = 1'b1;
   endtask

   task automatic test_cancel_vs_cup();
      sel = 3'd3;
      push(mk(3'd3, 3'b000, 0, 0, 1), 1);
      push(mk(3'd3, 3'b100, 1, 0, 1), 50);
      push(mk(3'd3, 3'b100, 0, 1, 1), 5 + LAT);
      push(mk(3'd3, 3'b110, 0, 0, 1), 100);
      fork
         press_confirm(PRESS);
         observe(4, "cancel_vs_cup");
         begin
            wait_valve(1'b1);
            repeat (4) @(negedge clk);
            fork
               press_cancel(PRESS);
               begin
                  repeat (LAT) @(negedge clk);
                  cup_present = 1'b0;
               end
            join
         end
      join
      check_idle("cancel_vs_cup_end");
      cup_present = 1'b1;
   endtask

   task automatic test_single_press();
      logic bad;
      sel = 3'd1;
      cup_present = 1'b0;
      push(mk(3'd1, 3'b000, 0, 0, 1), 1);
      fork
         press_confirm(20);
         observe(1, "single_press");
      join
      bad = 1'b0;
      repeat (40) begin
         @(negedge clk);
         bad = bad | (tup() !== mk(3'd1, 3'b001, 0, 0, 1));
      end
      checks++;
      if (bad !== 1'b0) begin
         failures++;
         $display("FAIL single_press_once got=reentered exp=fault_held");
      end
      fork
         press_cancel(PRESS);
         wait_idle("single_press_cancel");
      join
      cup_present = 1'b1;
   endtask

`ifdef DEBOUNCE_EN
   task automatic test_glitch();
      logic seen;
      sel = 3'd2;
      seen = 1'b0;
      confirm = 1'b1;
      repeat (5) begin
         @(negedge clk);
         seen = seen | busy;
      end
      confirm = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen = seen | busy;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL glitch_ignored got=busy1 exp=busy0");
      end
   endtask
`endif

   task automatic test_reset_mid_mix();
      logic seen;
      sel = 3'd4;
      confirm = 1'b1;
      wait_valve(1'b1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_idle("reset_mid_mix");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen = seen | busy;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL reset_held_confirm got=busy1 exp=busy0");
      end
      confirm = 1'b0;
      repeat (PRESS + 4) @(negedge clk);
      test_normal(3'd2);
   endtask

   initial begin
      test_reset();
      test_normal(3'd3);
      test_back_to_back();
      test_invalid();
      test_faults();
      test_cancel_fill();
      test_cup_loss_fill();
      test_cancel_vs_cup();
      test_single_press();
`ifdef DEBOUNCE_EN
      test_glitch();
`endif
      test_reset_mid_mix();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/controlador_maquina.md
CONTROLADOR_MAQUINA -- requirements
Module: controlador_maquina

Interface
REQ-001 The block SHALL have parameter FILL_CYCLES, default 50, cycles the water valve stays open.
REQ-002 The block SHALL have parameter MIX_CYCLES, default 30, cycles the mix valve stays open.
REQ-003 The block SHALL have parameter MSG_CYCLES, default 100, cycles a DONE/CANCEL code is held.
REQ-004 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, stable-input cycles needed (DEBOUNCE_EN only).
REQ-005 The block SHALL have port clk  input  1  system clock, rising edge.
REQ-006 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-007 The block SHALL have port sel  input  3  beverage switches; codes 1..5 are valid.
REQ-008 The block SHALL have ports confirm and cancel  input  1 each  asynchronous pushbuttons, active-high.
REQ-009 The block SHALL have ports cup_present, water_ok and ingredient_ok  input  1 each  level sensors, 1 = condition met.
REQ-010 The block SHALL have port bebida  output  3  latched beverage code; feeds the display's x,y,z inputs.
REQ-011 The block SHALL have port sensor  output  3  status code; feeds the display's k,l,m inputs.
REQ-012 The block SHALL have ports valve_water and valve_mix  output  1 each  actuator enables.
REQ-013 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 confirm and cancel SHALL pass through a 2-flop synchronizer; a rising edge SHALL produce a 1-cycle internal pulse.
REQ-015 Status codes: 000 OK, 001 no cup, 010 low water, 011 low ingredient, 100 dispensing, 101 done, 110 cancelled; 111 SHALL never be driven.
REQ-016 FSM states: IDLE, CHECK, FILL, MIX, MSG, FAULT.
REQ-017 IDLE: bebida=000, sensor=000, valves off. A confirm pulse with sel in 1..5 SHALL latch sel into bebida and enter CHECK next cycle; sel 0, 6 or 7 SHALL be ignored.
REQ-018 CHECK lasts 1 cycle. Fault priority is cup > water > ingredient: any fault SHALL go to FAULT with its code, otherwise to FILL.
REQ-019 FILL: valve_water=1, sensor=100 for exactly FILL_CYCLES cycles, then MIX.
REQ-020 MIX: valve_mix=1, sensor=100 for exactly MIX_CYCLES cycles, then MSG with sensor=101.
REQ-021 MSG: valves off, code held for exactly MSG_CYCLES cycles, then IDLE with bebida cleared.
REQ-022 A cancel pulse in CHECK, FILL or MIX SHALL turn both valves off on the next cycle and enter MSG with sensor=110.
REQ-023 cup_present falling low in FILL or MIX SHALL enter FAULT with sensor=001; valves off on the next cycle.
REQ-024 If cancel and a cup loss occur in the same cycle, cancel SHALL win.
REQ-025 FAULT: valves off, fault code held. A confirm pulse SHALL re-enter CHECK with bebida kept; a cancel pulse SHALL go to IDLE. If both pulse in the same cycle, cancel SHALL win.
REQ-026 Each state's timer SHALL clear on state entry; its width SHALL be $clog2 of the largest cycle parameter plus 1.
REQ-027 valve_water and valve_mix SHALL never be high in the same cycle.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, bebida=000, sensor=000, valves 0, busy 0, and clear the timers and synchronizers, including mid-dispense.
REQ-030 After rst_n is released, the first accepted confirm pulse SHALL come from a rising edge seen after release.

Configuration
REQ-031 With DEBOUNCE_EN defined, a synchronized button level SHALL be accepted only after DEBOUNCE_CYCLES consecutive stable cycles, using a per-button counter.
REQ-032 Without DEBOUNCE_EN, edge detection SHALL act directly on the synchronizer output, and no debounce counters SHALL exist.

Structure
REQ-033 The state enum, the status codes (REQ-015) and the valid beverage range SHALL live in shared package maquina_pkg, also used by the display decoders.
REQ-034 Synchronizer, optional debounce and edge detect SHALL form one sub-module, botao_sync, instantiated once per button.

Verification
REQ-035 Normal flow: sel=3, all sensors ok, confirm -> CHECK 1 cycle; valve_water high 50 cycles; valve_mix high 30 cycles; sensor=101 for 100 cycles; then bebida=000.
REQ-036 Fault: cup_present=0, sel=2, confirm -> sensor=001, valves never high; raise cup, confirm -> dispense proceeds with bebida=010.
REQ-037 Cancel: cancel at FILL cycle 10 -> valve_water low next cycle, sensor=110 for 100 cycles, then IDLE.
REQ-038 Priority: water_ok=0 and ingredient_ok=0 -> sensor=010; same-cycle cancel and cup loss in MIX -> sensor=110.
REQ-039 Invalid and reset: sel=6, confirm -> stays IDLE, busy=0; rst_n low mid-MIX -> all outputs 0 immediately.
REQ-040 DEBOUNCE_EN: a 5-cycle glitch on confirm -> ignored; a 20-cycle press -> exactly one accepted pulse.
